// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port data memory: IDLE -> ACCESS -> RESP per access.
// Define DMEM_ARB_FIXED_PRIO_EN for port-0 priority with a port-1 starvation counter; default is round robin.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [$clog2(MAX_WAIT+1)-1:0] dbg_wait
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                mem_en_q, mem_en_d;
  logic                gnt_sel;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
`else
  logic                last_q, last_d;
`endif

  // Tie-break for a contested IDLE decision.
  always_comb begin
    gnt_sel = req1 & ~req0;
    if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gnt_sel = (wait_cnt_q >= CNT_W'(MAX_WAIT));
`else
      gnt_sel = ~last_q;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ack0_d        = ack0_q;
    ack1_d        = ack1_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_en_d      = mem_en_q;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    wait_cnt_d    = wait_cnt_q;
`else
    last_d        = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        mem_en_d = 1'b0;
        if (req0 || req1) begin
          state_d       = S_ACCESS;
          gnt_d         = gnt_sel;
          mem_address_d = gnt_sel ? addr1 : addr0;
          mem_data_in_d = gnt_sel ? wdata1 : wdata0;
          mem_en_d      = gnt_sel ? we1 : we0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
          if (gnt_sel)
            wait_cnt_d = '0;
          else if (req1 && (wait_cnt_q < CNT_W'(MAX_WAIT)))
            wait_cnt_d = wait_cnt_q + 1'b1;
`else
          last_d = gnt_sel;
`endif
        end
      end
      S_ACCESS: begin
        // mem_en_q still holds the write flag here; reads capture pre-write data.
        if (gnt_q) begin
          ack1_d = 1'b1;
          if (!mem_en_q) rdata1_d = mem_data_out;
        end else begin
          ack0_d = 1'b1;
          if (!mem_en_q) rdata0_d = mem_data_out;
        end
        mem_en_d = 1'b0;
        state_d  = S_RESP;
      end
      S_RESP: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      gnt_q         <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_en_q      <= 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      wait_cnt_q    <= '0;
`else
      last_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_en_q      <= mem_en_d;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      wait_cnt_q    <= wait_cnt_d;
`else
      last_q        <= last_d;
`endif
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_en      = mem_en_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign dbg_wait    = wait_cnt_q;
`else
  assign dbg_wait    = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 memory preloaded mem[i]=5*i.
// Builds with or without DMEM_ARB_FIXED_PRIO_EN; the grant-order table follows the macro.
module tb_dmem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int MAX_WAIT = 2;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, mem_en, busy;
  logic [DATA_W-1:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [ADDR_W-1:0] mem_address;
  logic [1:0] dbg_state;
  logic [CNT_W-1:0] dbg_wait;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_en(mem_en),
    .mem_data_out(mem_data_out), .busy(busy), .dbg_state(dbg_state), .dbg_wait(dbg_wait)
  );

  // memory model: combinational read, write on posedge when mem_en
  logic [DATA_W-1:0] mem [1024];
  logic loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= DATA_W'(5 * i);
      loaded <= 1'b1;
    end else if (mem_en) begin
      mem[mem_address] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_address];

  // monitor: write-strobe placement, ack exclusivity, requester protocol
  int en_cycles = 0, en_bad = 0, overlap = 0, proto_err = 0;
  logic pend0 = 1'b0, pend1 = 1'b0;
  always @(negedge clk) begin
    if (mem_en) begin
      en_cycles++;
      if (!(busy && !ack0 && !ack1)) en_bad++;
    end
    if (ack0 && ack1) overlap++;
    if (!rst_n) begin
      pend0 = 1'b0;
      pend1 = 1'b0;
    end else begin
      if (pend0 && !req0 && !ack0) begin
        proto_err++;
        $display("FAIL req0_dropped got=0 exp=1 t=%0t", $time);
      end
      if (pend1 && !req1 && !ack1) begin
        proto_err++;
        $display("FAIL req1_dropped got=0 exp=1 t=%0t", $time);
      end
      pend0 = ack0 ? 1'b0 : (req0 | pend0);
      pend1 = ack1 ? 1'b0 : (req1 | pend1);
    end
  end

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
    check_val({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
    check_val({tag, "_rdata0"}, rdata0, 32'd0);
    check_val({tag, "_rdata1"}, rdata1, 32'd0);
    check_val({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    check_val({tag, "_mem_addr"}, {22'd0, mem_address}, 32'd0);
    check_val({tag, "_mem_din"}, mem_data_in, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Single access on one port; checks ACCESS, RESP and return to IDLE.
  task automatic single_access(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    tick();
    check_val("access_busy", {31'd0, busy}, 32'd1);
    check_val("access_addr", {22'd0, mem_address}, {22'd0, addr});
    check_val("access_en", {31'd0, mem_en}, {31'd0, we});
    check_val("access_noack", {30'd0, ack1, ack0}, 32'd0);
    if (we) check_val("access_din", mem_data_in, wdata);
    tick();
    check_val("resp_ack", {30'd0, ack1, ack0}, port ? 32'd2 : 32'd1);
    check_val("resp_rdata", port ? rdata1 : rdata0, exp_rdata);
    check_val("resp_en", {31'd0, mem_en}, 32'd0);
    if (port) req1 = 1'b0; else req0 = 1'b0;
    tick();
    check_val("idle_ack", {30'd0, ack1, ack0}, 32'd0);
    check_val("idle_busy", {31'd0, busy}, 32'd0);
    check_val("idle_rdata_held", port ? rdata1 : rdata0, exp_rdata);
  endtask

  // Both ports contend; each drops its req at its final ack. Grant order comes from exp_q.
  task automatic contest(input int want0, input int want1);
    int rem0, rem1, waited;
    logic [DATA_W-1:0] port;
    rem0 = want0; rem1 = want1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd20;
    for (int g = 0; g < want0 + want1; g++) begin
      waited = 0;
      tick();
      while (!(ack0 || ack1) && waited < 8) begin
        tick();
        waited++;
      end
      if (!(ack0 || ack1)) begin
        check_val("contest_timeout", 32'd0, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        return;
      end
      port = {31'd0, ack1};
      check_val("contest_order", port, exp_q.pop_front());
      check_val("contest_rdata", ack1 ? rdata1 : rdata0, ack1 ? 32'd100 : 32'd50);
      if (ack1) begin rem1--; if (rem1 == 0) req1 = 1'b0; end
      else      begin rem0--; if (rem0 == 0) req0 = 1'b0; end
    end
    tick();
    check_val("contest_done_busy", {31'd0, busy}, 32'd0);
  endtask

  int en_snap;

  initial begin
    // reset state
    do_reset();
    check_reset_outputs("reset");

    // port 0 read of addr 5: no write strobe
    en_snap = en_cycles;
    single_access(1'b0, 1'b0, 10'd5, 32'd0, 32'd25);
    check_val("read_no_en", en_cycles - en_snap, 32'd0);

    // port 1 writes addr 5, port 0 reads it back
    en_snap = en_cycles;
    single_access(1'b1, 1'b1, 10'd5, 32'hF0F0F0F0, 32'd0);
    check_val("write_mem5", mem[5], 32'hF0F0F0F0);
    check_val("write_en_cycles", en_cycles - en_snap, 32'd1);
    single_access(1'b0, 1'b0, 10'd5, 32'd0, 32'hF0F0F0F0);

    // top address on port 1
    single_access(1'b1, 1'b0, 10'd1023, 32'd0, 32'd5115);

    // contested reads from reset: 3 accesses on port 0, 2 on port 1
    do_reset();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_q = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd1};
`else
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
`endif
    contest(3, 2);

    // reset during ACCESS of a write: memory still commits, no ack
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd7; wdata0 = 32'h00FF00FF;
    tick();
    check_val("rst_mid_en", {31'd0, mem_en}, 32'd1);
    rst_n = 1'b0;
    tick();
    req0 = 1'b0; we0 = 1'b0;
    check_reset_outputs("rst_mid");
    check_val("rst_mid_mem7", mem[7], 32'h00FF00FF);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("rst_mid_noack", {30'd0, ack1, ack0}, 32'd0);
    check_val("rst_mid_idle", {31'd0, busy}, 32'd0);

    // whole-run invariants
    check_val("en_outside_access", en_bad, 32'd0);
    check_val("ack_overlap", overlap, 32'd0);
    check_val("req_protocol", proto_err, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
